// File: rtl/m92_sound_latch.sv
// rtl/m92_sound_latch.sv - M92 main-to-sound command latch with reply byte and sound-side register window.
// Optional FIFO command path enabled by M92_SNDLATCH_FIFO_EN; otherwise a single register plus full flag.
module m92_sound_latch #(
    parameter int DEPTH = 4
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        main_wr,
    input  logic [7:0]  main_din,
    input  logic        main_rd,
    output logic [15:0] main_dout,
    output logic        main_irq,
    input  logic        snd_cs,
    input  logic        snd_wr,
    input  logic        snd_rd,
    input  logic [1:0]  snd_a,
    input  logic [7:0]  snd_din,
    output logic [7:0]  snd_dout,
    output logic        snd_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic main_wr_q, main_rd_q, snd_wr_q, snd_rd_q;
    logic push, main_rd_e, snd_wr_e, snd_rd_e;
    logic pop_req, ack, ovf_clr, reply_wr;

    logic [CW-1:0] count, count_nxt;
    logic          empty;
    logic          do_push, do_pop, ovf_set, rearm_nxt;
    logic [7:0]    head, rd_data;

    logic          ovf, reply_pending, rearm, irq;
    logic [7:0]    reply;

    assign push      = main_wr & ~main_wr_q;
    assign main_rd_e = main_rd & ~main_rd_q;
    assign snd_wr_e  = (snd_cs & snd_wr) & ~snd_wr_q;
    assign snd_rd_e  = (snd_cs & snd_rd) & ~snd_rd_q;

    assign pop_req  = snd_rd_e & (snd_a == 2'd2);
    assign ack      = snd_wr_e & (snd_a == 2'd1);
    assign ovf_clr  = snd_wr_e & (snd_a == 2'd0);
    assign reply_wr = snd_wr_e & (snd_a == 2'd3);

    assign empty = (count == '0);

`ifdef M92_SNDLATCH_FIFO_EN
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full;

    assign full = (count == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a push while full still lands.
    always_comb begin
        do_pop    = pop_req & ~empty;
        do_push   = push & (~full | do_pop);
        ovf_set   = push & full & ~do_pop;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
        head      = mem[rd_ptr];
        rearm_nxt = ack & (count_nxt != '0);
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK_32M) begin
        if (do_push) mem[wr_ptr] <= main_din;
    end
`else
    logic [7:0] slot;
    logic       full;

    // count only ever holds 0 or 1 here and serves as the full flag.
    assign full = count[0];

    always_comb begin
        do_pop    = pop_req & full;
        do_push   = push;
        ovf_set   = push & full & ~do_pop;
        count_nxt = do_push ? CW'(1) : (do_pop ? '0 : count);
        head      = slot;
        rearm_nxt = 1'b0;
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            slot <= 8'hFF;
        end else if (do_push) begin
            slot <= main_din;
        end
    end
`endif

    always_comb begin
        rd_data = 8'hFF;
        case (snd_a)
            2'd0:    rd_data = {ovf, 5'b0, reply_pending, ~empty};
            2'd1:    rd_data = 8'hFF;
            2'd2:    rd_data = do_pop ? head : 8'hFF;
            default: rd_data = reply;
        endcase
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            main_wr_q     <= 1'b0;
            main_rd_q     <= 1'b0;
            snd_wr_q      <= 1'b0;
            snd_rd_q      <= 1'b0;
            count         <= '0;
            ovf           <= 1'b0;
            rearm         <= 1'b0;
            irq           <= 1'b0;
            reply         <= 8'hFF;
            reply_pending <= 1'b0;
            snd_dout      <= 8'hFF;
        end else begin
            main_wr_q <= main_wr;
            main_rd_q <= main_rd;
            snd_wr_q  <= snd_cs & snd_wr;
            snd_rd_q  <= snd_cs & snd_rd;
            count     <= count_nxt;

            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;

            // rearm drops irq for one cycle so each remaining byte gets a fresh edge.
            rearm <= rearm_nxt;
            irq   <= do_push | (irq & ~ack) | rearm;

            if (reply_wr) begin
                reply         <= snd_din;
                reply_pending <= 1'b1;
            end else if (main_rd_e) begin
                reply_pending <= 1'b0;
            end

            if (snd_rd_e) snd_dout <= rd_data;
        end
    end

    assign snd_irq   = irq;
    assign main_irq  = reply_pending;
    assign main_dout = {8'hFF, reply};

endmodule

// File: tb/tb_m92_sound_latch.sv
// tb/tb_m92_sound_latch.sv - scoreboard bench for m92_sound_latch, FIFO or single-register build.
module tb_m92_sound_latch;

`ifdef M92_SNDLATCH_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        main_wr;
    logic [7:0]  main_din;
    logic        main_rd;
    logic [15:0] main_dout;
    logic        main_irq;
    logic        snd_cs;
    logic        snd_wr;
    logic        snd_rd;
    logic [1:0]  snd_a;
    logic [7:0]  snd_din;
    logic [7:0]  snd_dout;
    logic        snd_irq;

    m92_sound_latch #(.DEPTH(4)) dut (
        .CLK_32M   (clk),
        .reset_n   (reset_n),
        .main_wr   (main_wr),
        .main_din  (main_din),
        .main_rd   (main_rd),
        .main_dout (main_dout),
        .main_irq  (main_irq),
        .snd_cs    (snd_cs),
        .snd_wr    (snd_wr),
        .snd_rd    (snd_rd),
        .snd_a     (snd_a),
        .snd_din   (snd_din),
        .snd_dout  (snd_dout),
        .snd_irq   (snd_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] e;
    } exp_t;

    exp_t sq[$];
    exp_t mq[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0] f4 [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hB0, 8'hFF};
    logic [7:0] s4 [5] = '{8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: watches strobe edges on the bus and checks the DUT answer.
    initial begin
        logic        prev_s, prev_m, cur_s, cur_m, ev_s, ev_m;
        logic [15:0] mdout_pre;
        exp_t        x;
        prev_s = 1'b0;
        prev_m = 1'b0;
        forever begin
            @(negedge clk);
            mdout_pre = main_dout;
            @(posedge clk);
            cur_s  = snd_cs & snd_rd;
            cur_m  = main_rd;
            ev_s   = cur_s & ~prev_s & reset_n;
            ev_m   = cur_m & ~prev_m & reset_n;
            prev_s = cur_s;
            prev_m = cur_m;
            if (ev_m) begin
                if (mq.size() == 0) chk("main_unexpected", mdout_pre, 16'hxxxx);
                else begin
                    x = mq.pop_front();
                    chk(x.nm, mdout_pre, x.e);
                end
            end
            #1;
            if (ev_s) begin
                if (sq.size() == 0) chk("snd_unexpected", {8'h00, snd_dout}, 16'hxxxx);
                else begin
                    x = sq.pop_front();
                    chk(x.nm, {8'h00, snd_dout}, x.e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] b, input int cyc);
        @(negedge clk);
        main_din = b;
        main_wr  = 1'b1;
        repeat (cyc) @(negedge clk);
        main_wr  = 1'b0;
    endtask

    task automatic snd_read(input logic [1:0] a, input logic [7:0] e, input string nm);
        sq.push_back('{nm, {8'h00, e}});
        @(negedge clk);
        snd_a  = a;
        snd_cs = 1'b1;
        snd_rd = 1'b1;
        @(negedge clk);
        snd_cs = 1'b0;
        snd_rd = 1'b0;
    endtask

    task automatic snd_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        snd_a   = a;
        snd_din = d;
        snd_cs  = 1'b1;
        snd_wr  = 1'b1;
        @(negedge clk);
        snd_cs  = 1'b0;
        snd_wr  = 1'b0;
    endtask

    task automatic main_read(input logic [15:0] e, input string nm);
        mq.push_back('{nm, e});
        @(negedge clk);
        main_rd = 1'b1;
        @(negedge clk);
        main_rd = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        main_wr  = 1'b1;
        main_din = 8'h77;
        main_rd  = 1'b0;
        snd_cs   = 1'b0;
        snd_wr   = 1'b0;
        snd_rd   = 1'b0;
        snd_a    = 2'd0;
        snd_din  = 8'h00;

        // Reset values, with main_wr held across release.
        repeat (3) @(negedge clk);
        chk("rst_snd_dout", {8'h00, snd_dout}, 16'h00FF);
        chk("rst_main_dout", main_dout, 16'hFFFF);
        chk("rst_snd_irq", {15'd0, snd_irq}, 16'd0);
        chk("rst_main_irq", {15'd0, main_irq}, 16'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        main_wr = 1'b0;
        chk("held_wr_irq", {15'd0, snd_irq}, 16'd1);
        snd_read(2'd0, 8'h01, "held_wr_status");
        snd_read(2'd2, 8'h77, "held_wr_pop");
        snd_read(2'd2, 8'hFF, "held_wr_once");
        snd_read(2'd0, 8'h00, "held_wr_empty");
        snd_write(2'd1, 8'h00);
        chk("ack_empty_low", {15'd0, snd_irq}, 16'd0);
        @(negedge clk);
        chk("ack_empty_norearm", {15'd0, snd_irq}, 16'd0);

        // Two 2-cycle pushes, ack with rearm, drain.
        push_byte(8'h12, 2);
        push_byte(8'h34, 2);
        @(negedge clk);
        chk("two_push_irq", {15'd0, snd_irq}, 16'd1);
        snd_read(2'd0, FIFO ? 8'h01 : 8'h81, "two_push_status");
        snd_write(2'd1, 8'h00);
        chk("ack_low", {15'd0, snd_irq}, 16'd0);
        @(negedge clk);
        chk("ack_rearm", {15'd0, snd_irq}, {15'd0, FIFO});
        snd_read(2'd2, FIFO ? 8'h12 : 8'h34, "pop_first");
        snd_read(2'd2, FIFO ? 8'h34 : 8'hFF, "pop_second");
        snd_read(2'd2, 8'hFF, "pop_empty");
        snd_read(2'd0, FIFO ? 8'h00 : 8'h80, "drained_status");
        snd_write(2'd0, 8'h00);
        snd_read(2'd0, 8'h00, "ovf_cleared_a");

        // Overflow with five pushes.
        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), 1);
        snd_read(2'd0, 8'h81, "ovf_status");
        for (int i = 0; i < 4; i++)
            snd_read(2'd2, FIFO ? 8'(8'hA0 + i) : ((i == 0) ? 8'hA4 : 8'hFF), "ovf_pop");
        snd_read(2'd0, 8'h80, "ovf_sticky");
        snd_write(2'd0, 8'h00);
        snd_read(2'd0, 8'h00, "ovf_cleared_b");

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), 1);
        snd_write(2'd0, 8'h00);
        sq.push_back('{"full_pp_pop", {8'h00, FIFO ? 8'hC0 : 8'hC3}});
        @(negedge clk);
        main_din = 8'hB0;
        main_wr  = 1'b1;
        snd_a    = 2'd2;
        snd_cs   = 1'b1;
        snd_rd   = 1'b1;
        @(negedge clk);
        main_wr  = 1'b0;
        snd_cs   = 1'b0;
        snd_rd   = 1'b0;
        snd_read(2'd0, 8'h01, "full_pp_status");
        for (int i = 0; i < 5; i++) snd_read(2'd2, FIFO ? f4[i] : s4[i], "full_pp_drain");

        // Reply path.
        snd_write(2'd3, 8'h5A);
        chk("reply_irq", {15'd0, main_irq}, 16'd1);
        chk("reply_dout", main_dout, 16'hFF5A);
        snd_read(2'd3, 8'h5A, "reply_readback");
        snd_read(2'd0, 8'h02, "reply_status");
        main_read(16'hFF5A, "main_read_5a");
        chk("reply_cleared", {15'd0, main_irq}, 16'd0);
        mq.push_back('{"main_read_coinc", 16'hFF5A});
        @(negedge clk);
        snd_a   = 2'd3;
        snd_din = 8'h6B;
        snd_cs  = 1'b1;
        snd_wr  = 1'b1;
        main_rd = 1'b1;
        @(negedge clk);
        snd_cs  = 1'b0;
        snd_wr  = 1'b0;
        main_rd = 1'b0;
        chk("coinc_irq", {15'd0, main_irq}, 16'd1);
        chk("coinc_dout", main_dout, 16'hFF6B);
        main_read(16'hFF6B, "main_read_6b");
        chk("reply_cleared_b", {15'd0, main_irq}, 16'd0);

        // Ack coincident with push keeps snd_irq high.
        snd_write(2'd1, 8'h00);
        chk("pre_ackpush_low", {15'd0, snd_irq}, 16'd0);
        push_byte(8'hD0, 1);
        chk("pre_ackpush_high", {15'd0, snd_irq}, 16'd1);
        @(negedge clk);
        main_din = 8'hD1;
        main_wr  = 1'b1;
        snd_a    = 2'd1;
        snd_cs   = 1'b1;
        snd_wr   = 1'b1;
        @(negedge clk);
        main_wr  = 1'b0;
        snd_cs   = 1'b0;
        snd_wr   = 1'b0;
        chk("ackpush_irq0", {15'd0, snd_irq}, 16'd1);
        @(negedge clk);
        chk("ackpush_irq1", {15'd0, snd_irq}, 16'd1);
        @(negedge clk);
        chk("ackpush_irq2", {15'd0, snd_irq}, 16'd1);
        snd_read(2'd2, FIFO ? 8'hD0 : 8'hD1, "ackpush_pop0");
        snd_read(2'd2, FIFO ? 8'hD1 : 8'hFF, "ackpush_pop1");

        repeat (3) @(negedge clk);
        chk("snd_queue_drained", 16'(sq.size()), 16'd0);
        chk("main_queue_drained", 16'(mq.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
